// File: rtl/seq_divider_10bit_pkg.sv
// Shared types and sizes for the sequential restoring divider.
// Optional remainder output is controlled by macro SEQ_DIV_REM_EN.
package seq_div_pkg;
    localparam int DIV_W = 10;
    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/seq_divider_10bit_if.sv
// Operand/result handshake bundle for seq_divider_10bit.
// The remainder signal exists only when SEQ_DIV_REM_EN is defined.
interface seq_divider_10bit_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
);
    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only while idle; out_valid holds with stable results until out_ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
`ifdef SEQ_DIV_REM_EN
    logic [WIDTH-1:0] remainder;
`endif
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
`ifdef SEQ_DIV_REM_EN
        input  remainder,
`endif
        input  in_ready, out_valid, quotient, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
`ifdef SEQ_DIV_REM_EN
        output remainder,
`endif
        output in_ready, out_valid, quotient, div_by_zero
    );
endinterface

// File: rtl/seq_divider_10bit_trial_subtractor.sv
// Ripple-borrow trial subtractor: diff = a - b, built as a + ~b + 1 over full-adder cells.
// borrow=1 means the true result is negative.
module trial_subtractor #(
    parameter int N = 11
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar k = 0; k < N; k++) begin : g_fa
        logic w_bn;
        assign w_bn         = ~b[k];
        assign diff[k]      = a[k] ^ w_bn ^ w_carry[k];
        assign w_carry[k+1] = (a[k] & w_bn) | (w_carry[k] & (a[k] ^ w_bn));
    end

    assign borrow = ~w_carry[N];
endmodule

// File: rtl/seq_divider_10bit.sv
// Unsigned restoring divider producing one quotient bit per clock; results appear WIDTH cycles after accept.
// Defining SEQ_DIV_REM_EN adds the registered remainder output.
module seq_divider_10bit
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_10bit_if.slave  bus,
    output div_state_t          o_state
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;
    logic             r_dbz;
`ifdef SEQ_DIV_REM_EN
    logic [WIDTH-1:0] r_rem;
`endif

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;
    logic             w_unused;

    // Bring down the next dividend bit, then try subtracting the divisor.
    assign w_shift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

    trial_subtractor #(.N(WIDTH + 1)) u_sub (
        .a      (w_shift),
        .b      ({1'b0, r_div}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign w_r_next = w_borrow ? w_shift : w_diff;
    assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
    assign w_last   = (r_count == CW'(WIDTH - 1));
    // Partial remainder stays below the divisor, so its top bit never carries information out.
    assign w_unused = r_r[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_state_next = CALC;
            CALC:    if (w_last)       w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_div   <= '0;
            r_quot  <= '0;
            r_dbz   <= 1'b0;
`ifdef SEQ_DIV_REM_EN
            r_rem   <= '0;
`endif
        end else begin
            if (r_state == IDLE && bus.in_valid) begin
                r_div   <= bus.divisor;
                r_q     <= bus.dividend;
                r_r     <= '0;
                r_count <= '0;
                r_dbz   <= (bus.divisor == '0);
            end else if (r_state == CALC) begin
                r_q     <= w_q_next;
                r_r     <= w_r_next;
                r_count <= r_count + CW'(1);
                if (w_last) begin
                    r_quot <= w_q_next;
`ifdef SEQ_DIV_REM_EN
                    r_rem  <= w_r_next[WIDTH-1:0];
`endif
                end
            end
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.quotient    = r_quot;
    assign bus.div_by_zero = r_dbz;
`ifdef SEQ_DIV_REM_EN
    assign bus.remainder   = r_rem;
`endif
    assign o_state         = r_state;
endmodule

// File: tb/tb_seq_divider_10bit.sv
// Directed bench for seq_divider_10bit: reset, corner divisions, back-pressure, mid-run reset.
// Remainder checks are compiled in when SEQ_DIV_REM_EN is defined.
module tb_seq_divider_10bit;
    import seq_div_pkg::*;

    logic       clk;
    logic       rst;
    div_state_t state_dbg;
    int         checks;
    int         failures;

    seq_divider_10bit_if #(.WIDTH(10)) bus ();

    seq_divider_10bit #(.WIDTH(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .o_state (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_div(input logic [9:0] a, input logic [9:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        check({tag, "_ov_low"}, bus.out_valid, 1'b0);
    endtask

    task automatic run_div(input string tag, input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] eq, input logic [9:0] er, input logic edbz);
        int lat;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        start_div(a, b);
        wait_result(lat);
        check({tag, "_latency"}, lat, 10);
        check({tag, "_quot"}, bus.quotient, eq);
`ifdef SEQ_DIV_REM_EN
        check({tag, "_rem"}, bus.remainder, er);
`else
        if (er !== 10'bx) check({tag, "_er_unused"}, 1'b0, 1'b0 & er[0]);
`endif
        check({tag, "_dbz"}, bus.div_by_zero, edbz);
        retire(tag);
    endtask

    initial begin
        int lat;
        logic stale;
        logic [9:0] ra, rb, rq, rr;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        tick(2);
        rst = 1'b0;

        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_quot", bus.quotient, 0);
        check("rst_dbz", bus.div_by_zero, 1'b0);
        check("rst_state", state_dbg, IDLE);
`ifdef SEQ_DIV_REM_EN
        check("rst_rem", bus.remainder, 0);
`endif

        // 100/7 with the consumer stalled, plus an ignored request during DONE.
        start_div(10'd100, 10'd7);
        check("bp_calc_in_ready", bus.in_ready, 1'b0);
        wait_result(lat);
        check("bp_latency", lat, 10);
        bus.dividend = 10'd50;
        bus.divisor  = 10'd5;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_quot", bus.quotient, 14);
`ifdef SEQ_DIV_REM_EN
            check("bp_rem", bus.remainder, 2);
`endif
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_dbz", bus.div_by_zero, 1'b0);
            tick(1);
        end
        bus.in_valid = 1'b0;
        retire("bp");
        check("bp_idle_in_ready", bus.in_ready, 1'b1);
        check("bp_hold_quot", bus.quotient, 14);

        run_div("max_by_1", 10'd1023, 10'd1, 10'd1023, 10'd0, 1'b0);
        run_div("small_by_big", 10'd3, 10'd10, 10'd0, 10'd3, 1'b0);
        run_div("by_zero", 10'd5, 10'd0, 10'd1023, 10'd5, 1'b1);
        run_div("div_100_7", 10'd100, 10'd7, 10'd14, 10'd2, 1'b0);

        // Reset four cycles into a calculation must discard it entirely.
        start_div(10'd300, 10'd7);
        tick(3);
        check("mid_state_calc", state_dbg, CALC);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_in_ready", bus.in_ready, 1'b1);
        check("mid_out_valid", bus.out_valid, 1'b0);
        check("mid_quot", bus.quotient, 0);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid) stale = 1'b1;
            tick(1);
        end
        check("mid_no_stale", stale, 1'b0);
        run_div("after_rst", 10'd200, 10'd9, 10'd22, 10'd2, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 10'($urandom_range(0, 1023));
            if (i % 16 == 0) rb = 10'($urandom_range(0, 3));
            if (rb == 0) begin
                rq = 10'd1023;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_div("rand", ra, rb, rq, rr, rb == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
